// File: rtl/seq_serializer.sv
// Serializes WIDTH-bit words onto one line, one bit per clock; bit 0 of a word appears the cycle after it is accepted.
// Backpressure: din_ready is high only when idle or during a word's last bit, so consecutive words stream with no gap.
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_din_valid,
    output logic             o_din_ready,
    output logic             o_out,
    output logic             o_out_valid,
    output logic             o_word_done,
    output logic             o_busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // One-hot encoding so that the two unused codes fall into the default arm and recover to idle.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b01,
        S_SHIFT = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [WIDTH-1:0] w_sr_shifted;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_last;
    logic             w_xfer;
    logic             w_out_nxt;
    logic             w_word_done_nxt;
    logic             w_shift_nxt;

    assign w_last       = (r_cnt == LAST);
    assign o_din_ready  = !i_rst && ((r_state == S_IDLE) || ((r_state == S_SHIFT) && w_last));
    assign w_xfer       = i_din_valid && o_din_ready;
    assign w_sr_shifted = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = S_IDLE;
        w_sr_nxt    = '0;
        w_cnt_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = S_SHIFT;
                    w_sr_nxt    = i_din;
                end
            end
            S_SHIFT: begin
                if (!w_last) begin
                    w_state_nxt = S_SHIFT;
                    w_sr_nxt    = w_sr_shifted;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end else if (w_xfer) begin
                    w_state_nxt = S_SHIFT;
                    w_sr_nxt    = i_din;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state they describe.
    assign w_shift_nxt     = (w_state_nxt == S_SHIFT);
    assign w_out_nxt       = w_shift_nxt && (MSB_FIRST ? w_sr_nxt[WIDTH-1] : w_sr_nxt[0]);
    assign w_word_done_nxt = w_shift_nxt && (w_cnt_nxt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            o_out       <= 1'b0;
            o_out_valid <= 1'b0;
            o_word_done <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_sr_nxt;
            r_cnt       <= w_cnt_nxt;
            o_out       <= w_out_nxt;
            o_out_valid <= w_shift_nxt;
            o_word_done <= w_word_done_nxt;
            o_busy      <= w_shift_nxt;
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: MSB-first and LSB-first instances share one stimulus stream and are
// compared cycle by cycle against a queue of pending bits built from each accepted word.
module tb_seq_serializer;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_din;
    logic       i_din_valid;

    logic rdy_m, out_m, vld_m, wd_m, busy_m;
    logic rdy_l, out_l, vld_l, wd_l, busy_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry: {last_bit_of_word, data_bit}; front is what should be on the line this cycle.
    logic [1:0] qm[$];
    logic [1:0] ql[$];

    logic       det_en   = 1'b0;
    logic [3:0] det_hist = 4'b0;
    int         det_bits = 0;
    int         det_hits = 0;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .i_clk(clk), .i_rst(i_rst), .i_din(i_din), .i_din_valid(i_din_valid),
        .o_din_ready(rdy_m), .o_out(out_m), .o_out_valid(vld_m),
        .o_word_done(wd_m), .o_busy(busy_m)
    );

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .i_clk(clk), .i_rst(i_rst), .i_din(i_din), .i_din_valid(i_din_valid),
        .o_din_ready(rdy_l), .o_out(out_l), .o_out_valid(vld_l),
        .o_word_done(wd_l), .o_busy(busy_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_word(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            qm.push_back({(i == 7), d[7 - i]});
            ql.push_back({(i == 7), d[i]});
        end
    endfunction

    // Called at a negedge: drive inputs, check outputs, advance model across the next rising edge.
    task automatic tick(input logic r, input logic v, input logic [7:0] d);
        logic exp_rdy;
        logic acc;
        i_rst       = r;
        i_din_valid = v;
        i_din       = d;
        #1;
        exp_rdy = !r && (qm.size() <= 1);
        chk("ready_msb", rdy_m, exp_rdy);
        chk("ready_lsb", rdy_l, exp_rdy);
        chk("out_msb",   out_m,  (qm.size() != 0) ? qm[0][0] : 1'b0);
        chk("valid_msb", vld_m,  qm.size() != 0);
        chk("done_msb",  wd_m,   (qm.size() != 0) ? qm[0][1] : 1'b0);
        chk("busy_msb",  busy_m, qm.size() != 0);
        chk("out_lsb",   out_l,  (ql.size() != 0) ? ql[0][0] : 1'b0);
        chk("valid_lsb", vld_l,  ql.size() != 0);
        chk("done_lsb",  wd_l,   (ql.size() != 0) ? ql[0][1] : 1'b0);
        chk("busy_lsb",  busy_l, ql.size() != 0);
        if (det_en && vld_m) begin
            det_hist = {det_hist[2:0], out_m};
            det_bits++;
            if (det_bits >= 4 && det_hist == 4'b1011) det_hits++;
        end
        acc = v && exp_rdy;
        @(posedge clk);
        if (r) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() != 0) void'(qm.pop_front());
            if (ql.size() != 0) void'(ql.pop_front());
            if (acc) push_word(d);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] held;
        logic       hv;
        i_rst = 1'b1;
        i_din_valid = 1'b0;
        i_din = 8'h00;
        @(negedge clk);

        // Reset held with a word offered: nothing may be taken.
        tick(1'b1, 1'b1, 8'hFF);
        tick(1'b1, 1'b1, 8'hFF);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);

        // Single word B4.
        tick(1'b0, 1'b1, 8'hB4);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 8'h00);

        // Back-to-back 05 then B0 with valid held; 1011 must be seen twice.
        det_en = 1'b1;
        tick(1'b0, 1'b1, 8'h05);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 8'hB0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 8'h00);
        det_en = 1'b0;
        chk("det_1011_hits", det_hits, 2);
        chk("det_bit_count", det_bits, 16);

        // Reset during the third bit of FF, then a clean word.
        tick(1'b0, 1'b1, 8'hFF);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h3C);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 8'h00);

        // Stall: next word offered throughout the current one.
        tick(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 8'h5A);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 8'h00);

        // Random traffic: upstream holds a refused word, din otherwise wanders.
        hv   = 1'b0;
        held = 8'h00;
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic v;
            logic [7:0] d;
            r = ($urandom_range(0, 39) == 0);
            if (hv) begin
                v = 1'b1;
                d = held;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                d = 8'($urandom);
            end
            hv   = v && (r || (qm.size() > 1));
            held = d;
            if (!v) d = 8'($urandom);
            tick(r, v, d);
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the overlapping Moore sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on a serial line that drives the detector's single-bit `in` input. Words accepted back-to-back stream with no idle gap, so patterns that span a word boundary are still detected. When no word is loaded, the line holds 0.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, bit order: 1 = bit WIDTH-1 goes out first, 0 = bit 0 goes out first.

- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- din  input  WIDTH  parallel word; sampled only on an accepted transfer.
- din_valid  input  1  upstream offers `din` this cycle.
- din_ready  output  1  block can take a word this cycle.
- out  output  1  serial bit; connects to the detector's `in`.
- out_valid  output  1  `out` carries a real data bit this cycle.
- word_done  output  1  one-cycle pulse while the last bit of a word is on `out`.
- busy  output  1  a word is being shifted.

## Operation
- Transfer rule: a transfer occurs on a rising edge where `din_valid && din_ready` is 1 and `rst` is 0. No other condition loads `din`.
- Registers:
  - shift register `sr[WIDTH-1:0]`.
  - bit counter `cnt`, width $clog2(WIDTH).
  - state register with two states, IDLE and SHIFT.
- All outputs except `din_ready` are registered.
- `din_ready` is combinational: `!rst && (state==IDLE || (state==SHIFT && cnt==WIDTH-1))`.
- IDLE:
  - `out`=0, `out_valid`=0, `busy`=0, `word_done`=0.
  - On a transfer: load `din` into `sr`, set `cnt`=0, go to SHIFT.
  - With no transfer: stay in IDLE.
- SHIFT:
  - `out` = `sr[WIDTH-1]` if MSB_FIRST, else `sr[0]`.
  - `out_valid`=1, `busy`=1.
  - `word_done` = (`cnt`==WIDTH-1).
  - When `cnt` < WIDTH-1: shift `sr` by one toward the output end, filling with 0, and increment `cnt`.
  - When `cnt` == WIDTH-1 with a transfer: reload `sr` from `din`, set `cnt`=0, stay in SHIFT. The next bit is the new word's first bit, with no bubble.
  - When `cnt` == WIDTH-1 with no transfer: go to IDLE, clear `sr`, `cnt`=0.
- `din` changing while a word is shifting has no effect. Holding `din_valid` high while `din_ready` is low is legal; the word is taken when `din_ready` rises.
- Illegal state encodings recover to IDLE on the next edge.

## Timing
- Reset (rst=1 at an edge) forces: state=IDLE, `sr`=0, `cnt`=0, `out`=0, `out_valid`=0, `word_done`=0, `busy`=0. `din_ready` reads 0 while `rst` is high and 1 in the first cycle after release.
- Reset mid-word aborts the word. The remaining bits are never emitted, and `out` is 0 from the cycle after the reset edge.
- Latency: for a word accepted at edge k, bit i (i=0..WIDTH-1 in emission order) is on `out` during the cycle after edge k+i.
- Throughput: one word per WIDTH cycles under continuous `din_valid`.
- After the last bit with no pending word, `out` returns to 0 and `out_valid` to 0 one cycle after `word_done`.
- Simultaneous `rst` and transfer: reset wins and the word is dropped; `din_ready` is 0, so a compliant upstream keeps holding it.

## Test plan
- Reset check: assert rst for 2 cycles with din_valid=1 and din=8'hFF -> `din_ready`=0 throughout. After release, `out`=0, `out_valid`=0, `busy`=0, and no word is loaded during reset.
- MSB-first word: WIDTH=8, MSB_FIRST=1, single word 8'hB4 -> `out` = 1,0,1,1,0,1,0,0 on 8 consecutive cycles starting one cycle after acceptance. `word_done` is high only on the 8th bit. The block then returns to IDLE with `out`=0.
- LSB-first word: WIDTH=8, MSB_FIRST=0, word 8'hB4 -> `out` = 0,0,1,0,1,1,0,1, with `out_valid` high for exactly 8 cycles.
- Back-to-back words: MSB-first 8'h05 then 8'hB0 with din_valid held high -> 16 contiguous valid bits 0000_0101_1011_0000 with no gap. The second word is accepted on the edge where `cnt`=7. A downstream detector reports exactly two "1011" matches, one of which spans the word boundary.
- Reset mid-word: accept 8'hFF, assert rst after 3 bits -> only bits 1,1,1 appear, then `out`=0 and `out_valid`=0. The next word after release starts cleanly from bit 0.
- Stall handling: din_valid high during SHIFT with `cnt`<7 -> `din_ready`=0 and `sr` is not disturbed. The pending word is taken exactly at `cnt`=7.
